// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per step.
// hi/lo hold the partial product or the remainder/quotient pair.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             mode,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] m;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, m};
  end

  // diff[WIDTH] set means the trial subtraction went negative: restore
  always_ff @(posedge clk) begin
    if (load) begin
      hi <= '0;
      lo <= a;
      m  <= b;
    end else if (step) begin
      if (!mode) begin
        hi <= sum[WIDTH:1];
        lo <= {sum[0], lo[WIDTH-1:1]};
      end else if (!diff[WIDTH]) begin
        hi <= diff[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi <= shifted[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle MIPS ALU: single-cycle logic/arith ops plus iterative multu/divu
// behind a start/busy/done handshake. Results are registered and held.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       aluCtr,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] aluRes,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             iterative;
  logic [3:0]       op_p0;
  logic [WIDTH-1:0] a_p0, b_p0;
  logic signed [WIDTH-1:0] sa_p0, sb_p0;
  logic [WIDTH-1:0] sum_p0, dif_p0;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic [WIDTH-1:0] res_lo, res_hi;
  logic             res_ovf;

  assign accept    = start && (state == S_IDLE);
  assign iterative = (aluCtr == OP_MULTU) || ((aluCtr == OP_DIVU) && (input2 != '0));
  assign busy      = (state != S_IDLE) || done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = iterative ? S_RUN : S_DONE;
      S_RUN:   if (cnt == CNT_LAST) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   cnt <= '0;
    else if (state == S_RUN && cnt != CNT_LAST)  cnt <= cnt + CW'(1);
    else                                         cnt <= '0;
  end

  // Stage p0: operands and opcode captured at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= aluCtr;
      a_p0  <= input1;
      b_p0  <= input2;
    end
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk  (clk),
    .load (accept),
    .mode (op_p0 == OP_DIVU),
    .step (state == S_RUN),
    .a    (input1),
    .b    (input2),
    .hi   (md_hi),
    .lo   (md_lo)
  );

  assign sa_p0  = a_p0;
  assign sb_p0  = b_p0;
  assign sum_p0 = a_p0 + b_p0;
  assign dif_p0 = a_p0 - b_p0;

  always_comb begin
    res_lo  = '0;
    res_hi  = '0;
    res_ovf = 1'b0;
    case (op_p0)
      OP_ADD: begin
        res_lo  = sum_p0;
        res_ovf = add_ovf(a_p0[WIDTH-1], b_p0[WIDTH-1], sum_p0[WIDTH-1]);
      end
      OP_SUB: begin
        res_lo  = dif_p0;
        res_ovf = add_ovf(a_p0[WIDTH-1], ~b_p0[WIDTH-1], dif_p0[WIDTH-1]);
      end
      OP_AND:   res_lo = a_p0 & b_p0;
      OP_OR:    res_lo = a_p0 | b_p0;
      OP_NOR:   res_lo = ~(a_p0 | b_p0);
      OP_SLT:   res_lo = {{(WIDTH-1){1'b0}}, (sa_p0 < sb_p0)};
      OP_MULTU: begin
        res_lo = md_lo;
        res_hi = md_hi;
      end
      OP_DIVU: begin
        if (b_p0 == '0) begin
          res_lo = '1;
          res_hi = a_p0;
        end else begin
          res_lo = md_lo;
          res_hi = md_hi;
        end
      end
      default: ;
    endcase
  end

  // Stage p1: registered results, updated only on completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done     <= 1'b0;
      aluRes   <= '0;
      hi       <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      if (state == S_DONE) begin
        aluRes   <= res_lo;
        hi       <= res_hi;
        zero     <= (res_lo == '0);
        overflow <= res_ovf;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: arithmetic model plus literal expectations,
// with a per-cycle check that the registered outputs hold between completions.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  aluCtr;
  logic [31:0] input1, input2;
  logic        busy, done, zero, overflow;
  logic [31:0] aluRes, hi;

  logic        start8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, zero8, ovf8;
  logic [7:0]  res8, hi8;

  int          total = 0;
  int          passed = 0;
  bit          chk_en = 0;
  logic [31:0] exp_res, exp_hi;
  logic        exp_zero, exp_ovf;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .aluCtr(aluCtr),
    .input1(input1), .input2(input2), .busy(busy), .done(done),
    .aluRes(aluRes), .hi(hi), .zero(zero), .overflow(overflow)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .aluCtr(op8),
    .input1(a8), .input2(b8), .busy(busy8), .done(done8),
    .aluRes(res8), .hi(hi8), .zero(zero8), .overflow(ovf8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Arithmetic reference: results from plain integer math on the operand values.
  function automatic void model(input int w, input logic [3:0] op,
                                input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] lo, output logic [63:0] ho,
                                output bit ov, output int lat);
    logic [63:0] mask, p;
    longint sa, sb, s, lim;
    mask = (64'd1 << w) - 64'd1;
    lim  = longint'(1) << (w - 1);
    sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    lo = 0; ho = 0; ov = 0; lat = 1;
    case (op)
      4'b0010: begin lo = (a + b) & mask; s = sa + sb; ov = (s >= lim) || (s < -lim); end
      4'b0110: begin lo = (a - b) & mask; s = sa - sb; ov = (s >= lim) || (s < -lim); end
      4'b0000: lo = a & b;
      4'b0001: lo = a | b;
      4'b0111: lo = (sa < sb) ? 64'd1 : 64'd0;
      4'b1100: lo = ~(a | b) & mask;
      4'b1000: begin p = a * b; lo = p & mask; ho = p >> w; lat = w + 1; end
      4'b1001: begin
        if (b == 0) begin lo = mask; ho = a; end
        else begin lo = a / b; ho = a % b; lat = w + 1; end
      end
      default: ;
    endcase
  endfunction

  // Registered outputs must equal the last completed result on every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("hold_aluRes", aluRes, exp_res);
      chk("hold_hi", hi, exp_hi);
      chk("hold_zero", zero, exp_zero);
      chk("hold_overflow", overflow, exp_ovf);
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at);
    logic [63:0] m_lo, m_hi;
    bit m_ov;
    int lat, n;
    model(32, op, {32'b0, a}, {32'b0, b}, m_lo, m_hi, m_ov, lat);
    aluCtr = op; input1 = a; input2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      chk("busy_inflight", busy, 1);
      if (n == inject_at) begin
        start = 1'b1; aluCtr = 4'b0010; input1 = 32'h1234; input2 = 32'h1;
      end else begin
        start = 1'b0; input1 = ~a; input2 = b ^ 32'h5;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("latency", n, lat);
    chk("busy_in_done", busy, 1);
    exp_res = m_lo[31:0]; exp_hi = m_hi[31:0];
    exp_zero = (m_lo[31:0] == 32'd0); exp_ovf = m_ov;
  endtask

  task automatic tick_idle();
    @(posedge clk); #1;
    chk("done_pulse_end", done, 0);
    chk("busy_end", busy, 0);
  endtask

  task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      output int n);
    op8 = op; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    bit saw_done;
    int n8;
    logic [63:0] m_lo, m_hi;
    bit m_ov;
    int m_lat;

    reset = 1'b1; start = 1'b0; aluCtr = 4'b0; input1 = '0; input2 = '0;
    start8 = 1'b0; op8 = 4'b0; a8 = '0; b8 = '0;
    exp_res = '0; exp_hi = '0; exp_zero = 1'b1; exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aluRes", aluRes, 0);
    chk("rst_hi", hi, 0);
    chk("rst_zero", zero, 1);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0;
    chk_en = 1;

    model(32, 4'b1000, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, m_lo, m_hi, m_ov, m_lat);
    chk("model_mul_hi", m_hi, 64'hFFFF_FFFE);
    chk("model_mul_lat", m_lat, 33);

    run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, -1);
    chk("add_lit_res", aluRes, 32'h8000_0000);
    chk("add_lit_ovf", overflow, 1);
    chk("add_lit_zero", zero, 0);
    tick_idle();

    run_op(4'b0110, 32'd5, 32'd5, -1);
    chk("sub_lit_res", aluRes, 0);
    chk("sub_lit_zero", zero, 1);
    tick_idle();

    run_op(4'b0110, 32'h8000_0000, 32'h1, -1);
    chk("sub_ovf_lit", overflow, 1);
    tick_idle();

    run_op(4'b0111, 32'hFFFF_FFFF, 32'h1, -1);
    chk("slt_lit", aluRes, 1);
    tick_idle();

    run_op(4'b1100, 32'h0, 32'h0, -1);
    chk("nor_lit", aluRes, 32'hFFFF_FFFF);
    tick_idle();

    run_op(4'b1111, 32'h123, 32'h456, -1);
    chk("badop_lit_res", aluRes, 0);
    chk("badop_lit_zero", zero, 1);
    tick_idle();

    run_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, -1);
    tick_idle();
    run_op(4'b0001, 32'hF0F0_1234, 32'h0FF0_FF00, -1);
    tick_idle();

    run_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    chk("multu_lit_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lit_lo", aluRes, 32'h0000_0001);
    tick_idle();

    run_op(4'b1001, 32'd100, 32'd7, -1);
    chk("divu_lit_q", aluRes, 14);
    chk("divu_lit_r", hi, 2);
    tick_idle();

    run_op(4'b1001, 32'd9, 32'd0, -1);
    chk("div0_lit_q", aluRes, 32'hFFFF_FFFF);
    chk("div0_lit_r", hi, 9);
    tick_idle();

    // add request in the middle of a multiply must be ignored
    run_op(4'b1000, 32'h1234_5678, 32'h9ABC_DEF0, 5);
    tick_idle();

    // back-to-back: second start issued during the done cycle
    run_op(4'b1001, 32'hDEAD_BEEF, 32'h0000_1234, -1);
    run_op(4'b0010, 32'd3, 32'd4, -1);
    chk("b2b_lit", aluRes, 7);
    tick_idle();

    // reset in the middle of a divide
    aluCtr = 4'b1001; input1 = 32'd1000; input2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_res = '0; exp_hi = '0; exp_zero = 1'b1; exp_ovf = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_res", aluRes, 0);
    chk("abort_zero", zero, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    saw_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    chk("abort_no_done", saw_done, 0);
    chk("abort_idle", busy, 0);

    run8(4'b1000, 8'hFF, 8'hFF, n8);
    chk("w8_mul_lat", n8, 9);
    chk("w8_mul_hi", hi8, 8'hFE);
    chk("w8_mul_lo", res8, 8'h01);
    @(posedge clk); #1;
    run8(4'b0010, 8'h7F, 8'h01, n8);
    chk("w8_add_lat", n8, 1);
    chk("w8_add_res", res8, 8'h80);
    chk("w8_add_ovf", ovf8, 1);

    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
